// File: rtl/vram_loader_pkg.sv
// Shared definitions for the VRAM loader: target codes, memory widths and the FIFO entry layout.
package vram_loader_pkg;

    localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

    // Memory address and data widths
    localparam int unsigned CHROW_AW = 8;
    localparam int unsigned PAL_AW   = 8;
    localparam int unsigned FONT_AW  = 12;
    localparam int unsigned CHROW_DW = 16;
    localparam int unsigned PAL_DW   = 16;
    localparam int unsigned FONT_DW  = 8;

    // Target codes carried in command byte bits [7:6]
    localparam logic [1:0] TGT_CHROW = 2'b00;
    localparam logic [1:0] TGT_PAL   = 2'b01;
    localparam logic [1:0] TGT_FONT  = 2'b10;
    localparam logic [1:0] TGT_NONE  = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StDataLo,
        StDataHi
    } parse_state_e;

    // One queued memory write; addr and data are sized for the widest target
    typedef struct packed {
        logic [1:0]          tgt;
        logic [FONT_AW-1:0]  addr;
        logic [CHROW_DW-1:0] data;
    } wr_entry_t;

    localparam int unsigned ENTRY_W = $bits(wr_entry_t);

    // Post-increment address, wrapping at the size of the selected memory
    function automatic logic [FONT_AW-1:0] next_addr(input logic [1:0]         tgt,
                                                     input logic [FONT_AW-1:0] addr);
        if (tgt == TGT_FONT) begin
            return addr + 12'd1;
        end
        return {4'h0, addr[7:0] + 8'd1};
    endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous write-queue FIFO with registered full/empty flags and occupancy count.
module vram_wr_fifo
    import vram_loader_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int unsigned WIDTH = ENTRY_W
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, empty_q;
    logic             push_ok, pop_ok;

    // A push is refused when full even if a pop happens in the same cycle
    assign push_ok = push & ~full_q;
    assign pop_ok  = pop & ~empty_q;

    // Next occupancy from accepted push/pop
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointers, count and flags
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_C);
            empty_q <= (count_d == '0);
        end
    end

    // Storage array; contents are don't-care while empty so no reset is needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;

endmodule

// File: rtl/vram_loader.sv
// Host byte-stream parser that queues memory writes and drains them into the
// character-row buffer, palette and font memories when writes are allowed.
module vram_loader
    import vram_loader_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [7:0]          host_data,
    input  logic                host_strobe,
    input  logic                host_cmd,
    output logic                host_busy,
    output logic                overflow,
    input  logic                wr_allow,
    output logic                chrowbuf_wr,
    output logic [CHROW_AW-1:0] chrowbuf_wr_addr,
    output logic [CHROW_DW-1:0] chrowbuf_wr_data,
    output logic                palette_wr,
    output logic [PAL_AW-1:0]   palette_wr_addr,
    output logic [PAL_DW-1:0]   palette_wr_data,
    output logic                fontmem_wr,
    output logic [FONT_AW-1:0]  fontmem_wr_addr,
    output logic [FONT_DW-1:0]  fontmem_wr_data
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    parse_state_e        state_q, state_d;
    logic [1:0]          tgt_q, tgt_d;
    logic [3:0]          nib_q, nib_d;
    logic [FONT_AW-1:0]  addr_q, addr_d;
    logic [7:0]          lo_q, lo_d;
    logic                ovf_q, ovf_d;
    logic                word_done;
    logic [CHROW_DW-1:0] word_data;

    logic                push, pop, full, empty;
    logic [CW-1:0]       count;
    wr_entry_t           push_entry, pop_entry;

    logic                chr_wr_q, pal_wr_q, font_wr_q;
    logic [CHROW_AW-1:0] chr_addr_q;
    logic [CHROW_DW-1:0] chr_data_q;
    logic [PAL_AW-1:0]   pal_addr_q;
    logic [PAL_DW-1:0]   pal_data_q;
    logic [FONT_AW-1:0]  font_addr_q;
    logic [FONT_DW-1:0]  font_data_q;

    // Parser state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Parser next state, latched fields, word assembly and push decision
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        nib_d     = nib_q;
        addr_d    = addr_q;
        lo_d      = lo_q;
        ovf_d     = ovf_q;
        word_done = 1'b0;
        word_data = '0;
        if (host_strobe) begin
            if (host_cmd) begin
                // A command restarts parsing from any state and drops a half word
                tgt_d   = host_data[7:6];
                nib_d   = host_data[3:0];
                ovf_d   = 1'b0;
                lo_d    = '0;
                state_d = StAddr;
            end else if (tgt_q != TGT_NONE) begin
                case (state_q)
                    StAddr: begin
                        addr_d  = (tgt_q == TGT_FONT) ? {nib_q, host_data} : {4'h0, host_data};
                        state_d = StDataLo;
                    end
                    StDataLo: begin
                        if (tgt_q == TGT_FONT) begin
                            word_done = 1'b1;
                            word_data = {8'h00, host_data};
                        end else begin
                            lo_d    = host_data;
                            state_d = StDataHi;
                        end
                    end
                    StDataHi: begin
                        word_done = 1'b1;
                        word_data = {host_data, lo_q};
                        state_d   = StDataLo;
                    end
                    default: ;
                endcase
            end
        end
        // Address advances even when the word is dropped
        if (word_done) begin
            addr_d = next_addr(tgt_q, addr_q);
            if (full) begin
                ovf_d = 1'b1;
            end
        end
    end

    assign push       = word_done & ~full;
    assign push_entry = {tgt_q, addr_q, word_data};

    // Latched command fields, address pointer, low byte and sticky overflow
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tgt_q  <= TGT_CHROW;
            nib_q  <= '0;
            addr_q <= '0;
            lo_q   <= '0;
            ovf_q  <= 1'b0;
        end else begin
            tgt_q  <= tgt_d;
            nib_q  <= nib_d;
            addr_q <= addr_d;
            lo_q   <= lo_d;
            ovf_q  <= ovf_d;
        end
    end

    vram_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (pop_entry),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign pop = wr_allow & ~empty;

    // Drain: register the popped entry and pulse the selected strobe for one cycle
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            chr_wr_q    <= 1'b1;
            pal_wr_q    <= 1'b1;
            font_wr_q   <= 1'b1;
            chr_addr_q  <= '0;
            chr_data_q  <= '0;
            pal_addr_q  <= '0;
            pal_data_q  <= '0;
            font_addr_q <= '0;
            font_data_q <= '0;
        end else begin
            chr_wr_q  <= 1'b1;
            pal_wr_q  <= 1'b1;
            font_wr_q <= 1'b1;
            if (pop) begin
                case (pop_entry.tgt)
                    TGT_CHROW: begin
                        chr_wr_q   <= 1'b0;
                        chr_addr_q <= pop_entry.addr[CHROW_AW-1:0];
                        chr_data_q <= pop_entry.data;
                    end
                    TGT_PAL: begin
                        pal_wr_q   <= 1'b0;
                        pal_addr_q <= pop_entry.addr[PAL_AW-1:0];
                        pal_data_q <= pop_entry.data;
                    end
                    TGT_FONT: begin
                        font_wr_q   <= 1'b0;
                        font_addr_q <= pop_entry.addr;
                        font_data_q <= pop_entry.data[FONT_DW-1:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign host_busy        = (count == DEPTH_C);
    assign overflow         = ovf_q;
    assign chrowbuf_wr      = chr_wr_q;
    assign chrowbuf_wr_addr = chr_addr_q;
    assign chrowbuf_wr_data = chr_data_q;
    assign palette_wr       = pal_wr_q;
    assign palette_wr_addr  = pal_addr_q;
    assign palette_wr_data  = pal_data_q;
    assign fontmem_wr       = font_wr_q;
    assign fontmem_wr_addr  = font_addr_q;
    assign fontmem_wr_data  = font_data_q;

endmodule

// File: tb/tb_vram_loader.sv
// Bench for vram_loader: directed scenarios with literal expectations plus random
// traffic, all compared every cycle against a queue-based reference model.
module tb_vram_loader;

    localparam int DEPTH = 4;

    logic        clk;
    logic        nrst;
    logic [7:0]  host_data;
    logic        host_strobe;
    logic        host_cmd;
    logic        host_busy;
    logic        overflow;
    logic        wr_allow;
    logic        chrowbuf_wr;
    logic [7:0]  chrowbuf_wr_addr;
    logic [15:0] chrowbuf_wr_data;
    logic        palette_wr;
    logic [7:0]  palette_wr_addr;
    logic [15:0] palette_wr_data;
    logic        fontmem_wr;
    logic [11:0] fontmem_wr_addr;
    logic [7:0]  fontmem_wr_data;

    vram_loader #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .nrst             (nrst),
        .host_data        (host_data),
        .host_strobe      (host_strobe),
        .host_cmd         (host_cmd),
        .host_busy        (host_busy),
        .overflow         (overflow),
        .wr_allow         (wr_allow),
        .chrowbuf_wr      (chrowbuf_wr),
        .chrowbuf_wr_addr (chrowbuf_wr_addr),
        .chrowbuf_wr_data (chrowbuf_wr_data),
        .palette_wr       (palette_wr),
        .palette_wr_addr  (palette_wr_addr),
        .palette_wr_data  (palette_wr_data),
        .fontmem_wr       (fontmem_wr),
        .fontmem_wr_addr  (fontmem_wr_addr),
        .fontmem_wr_data  (fontmem_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    typedef struct {
        int tgt;
        int addr;
        int data;
    } wr_t;

    // Reference model: pending writes as a plain queue, parser as a few flags
    wr_t mq[$];
    wr_t dut_log[$];
    bit  m_active, m_need_addr, m_have_lo, m_ovf, m_full;
    int  m_tgt, m_nib, m_addr, m_lo;
    int  e_chr_wr, e_pal_wr, e_font_wr, e_busy;
    int  e_chr_addr, e_chr_data, e_pal_addr, e_pal_data, e_font_addr, e_font_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_word(input int data);
        wr_t w;
        w.tgt  = m_tgt;
        w.addr = m_addr;
        w.data = data;
        if (!m_full) mq.push_back(w);
        else m_ovf = 1'b1;
        m_addr = (m_addr + 1) % ((m_tgt == 2) ? 4096 : 256);
    endtask

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mq.delete();
            m_active = 0; m_need_addr = 0; m_have_lo = 0; m_ovf = 0;
            m_tgt = 0; m_nib = 0; m_addr = 0; m_lo = 0;
            e_chr_wr = 1; e_pal_wr = 1; e_font_wr = 1; e_busy = 0;
            e_chr_addr = 0; e_chr_data = 0; e_pal_addr = 0; e_pal_data = 0;
            e_font_addr = 0; e_font_data = 0;
        end else begin
            wr_t w;
            m_full = (mq.size() == DEPTH);
            e_chr_wr = 1; e_pal_wr = 1; e_font_wr = 1;
            if (wr_allow && mq.size() != 0) begin
                w = mq.pop_front();
                if (w.tgt == 0) begin
                    e_chr_wr = 0; e_chr_addr = w.addr; e_chr_data = w.data;
                end else if (w.tgt == 1) begin
                    e_pal_wr = 0; e_pal_addr = w.addr; e_pal_data = w.data;
                end else begin
                    e_font_wr = 0; e_font_addr = w.addr; e_font_data = w.data;
                end
            end
            if (host_strobe) begin
                if (host_cmd) begin
                    m_tgt = int'(host_data[7:6]);
                    m_nib = int'(host_data[3:0]);
                    m_ovf = 0; m_active = 1; m_need_addr = 1; m_have_lo = 0;
                end else if (m_active && m_tgt != 3) begin
                    if (m_need_addr) begin
                        m_addr = (m_tgt == 2) ? (m_nib * 256 + int'(host_data)) : int'(host_data);
                        m_need_addr = 0;
                    end else if (m_tgt == 2) begin
                        model_word(int'(host_data));
                    end else if (!m_have_lo) begin
                        m_lo = int'(host_data);
                        m_have_lo = 1;
                    end else begin
                        model_word(int'(host_data) * 256 + m_lo);
                        m_have_lo = 0;
                    end
                end
            end
            e_busy = (mq.size() == DEPTH) ? 1 : 0;
        end
    end

    // Compare every cycle on the falling edge and log observed writes
    always @(negedge clk) begin
        wr_t w;
        if (chk_en) begin
            chk("host_busy", host_busy, e_busy);
            chk("overflow", overflow, m_ovf);
            chk("chrowbuf_wr", chrowbuf_wr, e_chr_wr);
            chk("chrowbuf_wr_addr", chrowbuf_wr_addr, e_chr_addr);
            chk("chrowbuf_wr_data", chrowbuf_wr_data, e_chr_data);
            chk("palette_wr", palette_wr, e_pal_wr);
            chk("palette_wr_addr", palette_wr_addr, e_pal_addr);
            chk("palette_wr_data", palette_wr_data, e_pal_data);
            chk("fontmem_wr", fontmem_wr, e_font_wr);
            chk("fontmem_wr_addr", fontmem_wr_addr, e_font_addr);
            chk("fontmem_wr_data", fontmem_wr_data, e_font_data);
        end
        if (chrowbuf_wr === 1'b0) begin
            w.tgt = 0; w.addr = int'(chrowbuf_wr_addr); w.data = int'(chrowbuf_wr_data);
            dut_log.push_back(w);
        end
        if (palette_wr === 1'b0) begin
            w.tgt = 1; w.addr = int'(palette_wr_addr); w.data = int'(palette_wr_data);
            dut_log.push_back(w);
        end
        if (fontmem_wr === 1'b0) begin
            w.tgt = 2; w.addr = int'(fontmem_wr_addr); w.data = int'(fontmem_wr_data);
            dut_log.push_back(w);
        end
    end

    task automatic step(input logic s, input logic c, input logic [7:0] d);
        host_strobe = s;
        host_cmd    = c;
        host_data   = d;
        @(posedge clk);
        #1;
        host_strobe = 1'b0;
        host_cmd    = 1'b0;
    endtask

    task automatic send(input logic c, input logic [7:0] d);
        step(1'b1, c, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic expect_log(input int idx, input int tgt, input int addr, input int data);
        if (idx >= dut_log.size()) begin
            checks++;
            errors++;
            $display("FAIL log_entry: got %0d writes expected entry %0d", dut_log.size(), idx);
        end else begin
            chk("log_tgt", dut_log[idx].tgt, tgt);
            chk("log_addr", dut_log[idx].addr, addr);
            chk("log_data", dut_log[idx].data, data);
        end
    endtask

    initial begin
        int mode_hold;
        nrst        = 1'b0;
        host_data   = 8'h00;
        host_strobe = 1'b0;
        host_cmd    = 1'b0;
        wr_allow    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst_chrowbuf_wr", chrowbuf_wr, 1);
        chk("rst_fontmem_wr", fontmem_wr, 1);
        chk("rst_host_busy", host_busy, 0);
        chk("rst_fontmem_addr", fontmem_wr_addr, 0);
        nrst = 1'b1;
        idle(2);

        // Single chrowbuf word
        wr_allow = 1'b1;
        dut_log.delete();
        send(1, 8'h00); send(0, 8'h10); send(0, 8'h34); send(0, 8'h12);
        idle(4);
        chk("chrow_count", dut_log.size(), 1);
        expect_log(0, 0, 'h10, 'h1234);

        // Fontmem with nibble carry across 0x3FF
        dut_log.delete();
        send(1, 8'h83); send(0, 8'hFF); send(0, 8'hAA); send(0, 8'hBB);
        idle(4);
        chk("font_count", dut_log.size(), 2);
        expect_log(0, 2, 'h3FF, 'hAA);
        expect_log(1, 2, 'h400, 'hBB);

        // Palette address wrap 0xFF -> 0x00
        dut_log.delete();
        send(1, 8'h40); send(0, 8'hFF);
        send(0, 8'h11); send(0, 8'h22); send(0, 8'h33); send(0, 8'h44);
        idle(4);
        chk("pal_count", dut_log.size(), 2);
        expect_log(0, 1, 'hFF, 'h2211);
        expect_log(1, 1, 'h00, 'h4433);

        // Fill while stalled, drop the fifth word, then drain
        wr_allow = 1'b0;
        dut_log.delete();
        send(1, 8'h80); send(0, 8'h20);
        send(0, 8'hA0); send(0, 8'hA1); send(0, 8'hA2);
        chk("busy_after_3", host_busy, 0);
        send(0, 8'hA3);
        chk("busy_after_4", host_busy, 1);
        chk("ovf_after_4", overflow, 0);
        send(0, 8'hA4);
        chk("ovf_after_5", overflow, 1);
        idle(3);
        chk("held_count", dut_log.size(), 0);
        wr_allow = 1'b1;
        idle(8);
        chk("drain_count", dut_log.size(), 4);
        for (int i = 0; i < 4; i++) expect_log(i, 2, 'h20 + i, 'hA0 + i);
        chk("busy_after_drain", host_busy, 0);
        send(1, 8'h00);
        chk("ovf_cleared", overflow, 0);

        // Half word abandoned by a new command
        dut_log.delete();
        send(0, 8'h05); send(0, 8'h77);
        send(1, 8'h40); send(0, 8'h09); send(0, 8'h01); send(0, 8'h02);
        idle(4);
        chk("restart_count", dut_log.size(), 1);
        expect_log(0, 1, 'h09, 'h0201);

        // Reset with three queued entries
        wr_allow = 1'b0;
        send(1, 8'h80); send(0, 8'h00); send(0, 8'h01); send(0, 8'h02); send(0, 8'h03);
        idle(1);
        nrst = 1'b0;
        #2;
        chk("rst_mid_chr_wr", chrowbuf_wr, 1);
        chk("rst_mid_pal_wr", palette_wr, 1);
        chk("rst_mid_font_wr", fontmem_wr, 1);
        chk("rst_mid_busy", host_busy, 0);
        idle(2);
        dut_log.delete();
        nrst     = 1'b1;
        wr_allow = 1'b1;
        idle(8);
        chk("post_reset_writes", dut_log.size(), 0);

        // Random traffic
        mode_hold = 1;
        for (int i = 0; i < 3000; i++) begin
            int r;
            if ($urandom_range(0, 24) == 0) mode_hold = ~mode_hold & 1;
            wr_allow = (mode_hold != 0) ? ($urandom_range(0, 7) != 0) : 1'b0;
            if (i == 1500) begin
                nrst = 1'b0;
                idle(2);
                nrst = 1'b1;
            end
            r = $urandom_range(0, 15);
            if (r == 0) send(1, 8'($urandom_range(0, 255)));
            else if (r < 11) send(0, 8'($urandom_range(0, 255)));
            else idle(1);
        end
        wr_allow = 1'b1;
        idle(10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_loader.md
VRAM_LOADER -- requirements
Module: vram_loader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning number of queued memory writes (power of two).
REQ-002 SHALL have port clk, input, 1, meaning 40 MHz pixel clock; one clock domain only.
REQ-003 SHALL have port nrst, input, 1, meaning asynchronous active-low reset.
REQ-004 SHALL have port host_data, input, 8, meaning host byte, already synchronized to clk.
REQ-005 SHALL have port host_strobe, input, 1, meaning one-cycle pulse marking a valid host_data byte.
REQ-006 SHALL have port host_cmd, input, 1, meaning 1 = command byte, 0 = data byte; sampled with host_strobe.
REQ-007 SHALL have port host_busy, output, 1, meaning FIFO full.
REQ-008 SHALL have port overflow, output, 1, meaning sticky flag set when a word was dropped.
REQ-009 SHALL have port wr_allow, input, 1, meaning 1 = memories may be written this cycle.
REQ-010 SHALL have ports chrowbuf_wr (output, 1, active-low strobe), chrowbuf_wr_addr (output, 8) and chrowbuf_wr_data (output, 16).
REQ-011 SHALL have ports palette_wr (output, 1, active-low strobe), palette_wr_addr (output, 8) and palette_wr_data (output, 16).
REQ-012 SHALL have ports fontmem_wr (output, 1, active-low strobe), fontmem_wr_addr (output, 12) and fontmem_wr_data (output, 8).

Function
REQ-013 Command byte SHALL decode as follows: bits[7:6] target (00 chrowbuf, 01 palette, 10 fontmem, 11 reserved); bits[3:0] upper address nibble (fontmem only; ignored otherwise).
REQ-014 Parser SHALL use four states: IDLE, ADDR, DATA_LO, DATA_HI.
REQ-015 A command byte SHALL latch target and nibble, clear overflow, discard any partial word, and move the parser to ADDR from any state.
REQ-016 A data byte in IDLE, or any byte after target 11, SHALL be ignored (state unchanged).
REQ-017 In ADDR, a data byte SHALL set addr[7:0] and move the parser to DATA_LO; for fontmem, addr = {nibble, byte}.
REQ-018 For 16-bit targets, a DATA_LO byte SHALL be stored as the low byte (-> DATA_HI), and a DATA_HI byte SHALL complete the word {hi, lo} (-> DATA_LO).
REQ-019 For fontmem, each DATA_LO byte SHALL complete a word; the parser stays in DATA_LO.
REQ-020 Each completed word SHALL push {target, addr, data} into the FIFO and then increment addr modulo the target size (256 or 4096); 0xFF SHALL wrap to 0x00 and 0xFFF to 0x000.
REQ-021 A push SHALL be accepted iff the FIFO is not full at that cycle, regardless of a same-cycle pop; a rejected word SHALL set overflow and SHALL still advance addr.
REQ-022 host_busy SHALL equal (count == FIFO_DEPTH), registered.
REQ-023 Drain: when the FIFO is non-empty and wr_allow = 1, the block SHALL pop one entry and, on the next cycle, drive the selected *_wr low for exactly one cycle with the registered addr/data; all other strobes SHALL stay high.
REQ-024 Drain SHALL allow at most one write per cycle; back-to-back writes are allowed while wr_allow stays 1.
REQ-025 Drain SHALL be in order; with wr_allow = 0 the FIFO SHALL hold its contents.
REQ-026 Latency from the completing strobe to the write strobe SHALL be 2 cycles minimum (push, pop, strobe).
REQ-027 *_wr_addr and *_wr_data SHALL hold their last values when the strobe is inactive.

Reset
REQ-028 While nrst = 0, all *_wr outputs SHALL be 1, all addr/data outputs 0, host_busy 0, overflow 0, the parser IDLE, the FIFO empty and the latched addr 0.
REQ-029 Reset mid-transaction SHALL discard partial words and queued entries; no strobe SHALL be issued after deassertion until new host traffic arrives.

Structure
REQ-030 A shared package SHALL hold the target codes (TGT_CHROW, TGT_PAL, TGT_FONT, TGT_NONE), the address widths (8/12), the data widths (16/8) and the FIFO_DEPTH default.
REQ-031 The FIFO SHALL be a separate sub-module vram_wr_fifo: synchronous, with push/pop/full/empty/count and 30-bit entries, asynchronously reset.

Verification
REQ-032 Bench SHALL cover: cmd 0x00, data 0x10, 0x34, 0x12, with wr_allow = 1 -> one chrowbuf_wr low pulse, addr 0x10, data 0x1234.
REQ-033 Bench SHALL cover: cmd 0x83, data 0xFF, 0xAA, 0xBB -> fontmem writes at 0x3FF (0xAA) then 0x400 (0xBB).
REQ-034 Bench SHALL cover: cmd 0x40, addr 0xFF, then two words -> palette writes at 0xFF then 0x00 (wrap).
REQ-035 Bench SHALL cover: wr_allow = 0 with 5 fontmem words pushed -> host_busy = 1 after the 4th, overflow = 1, then wr_allow = 1 -> exactly 4 writes in order; the next cmd byte clears overflow.
REQ-036 Bench SHALL cover: cmd 0x00, addr 0x05, low byte only, then cmd 0x40 -> no chrowbuf write; the parser restarts in ADDR for palette.
REQ-037 Bench SHALL cover: nrst pulsed low with 3 entries queued -> all strobes high and no writes after release.
